// File: rtl/vga_pkg.sv
// Shared definitions for the VGA board renderer: loader states, header layout
// and the image RAM placement.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    PIXELS = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } loader_state_t;

  localparam int          HDR_BYTES    = 16;
  localparam logic [17:0] BASE_ADDRESS = 18'h10;

  localparam logic [3:0] HDR_W_HI = 4'd0;
  localparam logic [3:0] HDR_W_LO = 4'd1;
  localparam logic [3:0] HDR_H_HI = 4'd4;
  localparam logic [3:0] HDR_H_LO = 4'd5;

  // True when both dimensions are non-zero and the pixel area fits behind the header.
  function automatic logic header_fits(input logic [15:0] w, input logic [15:0] h,
                                       input logic [31:0] prod, input logic [31:0] limit);
    return (w != 16'd0) && (h != 16'd0) && (prod <= limit);
  endfunction

endpackage

// File: rtl/vga_image_loader_if.sv
// Valid/ready byte stream from the host receive path into the image loader.
interface vga_image_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/vga_image_loader.sv
// Streams a 16-byte header plus grey-scale pixels into the image RAM write
// port, parsing the dimensions and rejecting images that do not fit.
module vga_image_loader
  import vga_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int MEM_WORDS = 262144
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  vga_image_loader_if.slave    in_bus,
  output logic [ADDR_W-1:0]    wraddress,
  output logic [7:0]           wrdata,
  output logic                 wren,
  output logic [15:0]          img_width,
  output logic [15:0]          img_height,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [31:0] PIX_LIMIT = 32'(MEM_WORDS - HDR_BYTES);

  loader_state_t     state_r, next_state_s;
  logic              ready_s, busy_s, accept_s;
  logic              last_hdr_s, last_pix_s, hdr_ok_s, rearm_s;
  logic [3:0]        hdr_idx_s;
  logic [ADDR_W-1:0] addr_cnt_r, rem_r, wraddress_r;
  logic [7:0]        w_hi_r, h_hi_r, wrdata_r;
  logic [15:0]       width_r, height_r;
  logic [31:0]       prod_r;
  logic              wren_r, done_r, error_r;

  // Header and pixel addresses are one contiguous run because pixels start right after the header.
  assign hdr_idx_s  = addr_cnt_r[3:0];
  assign accept_s   = in_bus.in_valid && ready_s;
  assign last_hdr_s = (state_r == HEADER) && accept_s && (hdr_idx_s == 4'd15);
  assign last_pix_s = (state_r == PIXELS) && accept_s && (rem_r == ADDR_W'(1));
  assign hdr_ok_s   = header_fits(width_r, height_r, prod_r, PIX_LIMIT);
  assign rearm_s    = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, DONE, ERROR: begin
        if (start) next_state_s = HEADER;
        else       next_state_s = state_r;
      end
      HEADER: begin
        if (last_hdr_s) next_state_s = hdr_ok_s ? PIXELS : ERROR;
        else            next_state_s = HEADER;
      end
      PIXELS: begin
        if (last_pix_s) next_state_s = DONE;
        else            next_state_s = PIXELS;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Moore decode of ready and busy from the state register.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      HEADER, PIXELS: begin
        ready_s = 1'b1;
        busy_s  = 1'b1;
      end
      ERROR:   ready_s = 1'b1;
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Address counter, header field capture, pixel product and remaining-pixel counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt_r <= '0;
      rem_r      <= '0;
      w_hi_r     <= 8'd0;
      h_hi_r     <= 8'd0;
      width_r    <= 16'd0;
      height_r   <= 16'd0;
      prod_r     <= 32'd0;
    end else begin
      if (rearm_s)                 addr_cnt_r <= '0;
      else if (accept_s && busy_s) addr_cnt_r <= addr_cnt_r + ADDR_W'(1);

      if ((state_r == HEADER) && accept_s) begin
        case (hdr_idx_s)
          HDR_W_HI: w_hi_r   <= in_bus.in_data;
          HDR_W_LO: width_r  <= {w_hi_r, in_bus.in_data};
          HDR_H_HI: h_hi_r   <= in_bus.in_data;
          HDR_H_LO: height_r <= {h_hi_r, in_bus.in_data};
          default: begin
          end
        endcase
      end

      prod_r <= 32'(width_r) * 32'(height_r);

      if (last_hdr_s)                           rem_r <= prod_r[ADDR_W-1:0];
      else if ((state_r == PIXELS) && accept_s) rem_r <= rem_r - ADDR_W'(1);
    end
  end

  // RAM write-port register stage and status flags; bytes drained in ERROR never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wren_r      <= 1'b0;
      wraddress_r <= '0;
      wrdata_r    <= 8'd0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      wren_r      <= accept_s && busy_s;
      wraddress_r <= addr_cnt_r;
      wrdata_r    <= in_bus.in_data;
      done_r      <= last_pix_s;
      error_r     <= (next_state_s == ERROR);
    end
  end

  assign in_bus.in_ready = ready_s;
  assign busy            = busy_s;
  assign wren            = wren_r;
  assign wraddress       = wraddress_r;
  assign wrdata          = wrdata_r;
  assign done            = done_r;
  assign error           = error_r;
  assign img_width       = width_r;
  assign img_height      = height_r;

endmodule

// File: tb/tb_vga_image_loader.sv
// Self-checking bench for vga_image_loader: random images against a
// write-list model derived from the header format.
module tb_vga_image_loader;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [17:0] wraddress;
  logic [7:0]  wrdata;
  logic        wren, busy, done, error;
  logic [15:0] img_width, img_height;

  vga_image_loader_if bus();

  vga_image_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_bus(bus.slave),
    .wraddress(wraddress), .wrdata(wrdata), .wren(wren),
    .img_width(img_width), .img_height(img_height),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Write monitor: records every RAM write and catches writes with no accept one cycle earlier.
  int wr_addr_q[$];
  int wr_data_q[$];
  int done_cnt = 0;
  int done_addr = -1;
  int lat_err = 0;
  bit acc_prev = 1'b0;
  always @(negedge clk) begin
    if (wren) begin
      wr_addr_q.push_back(int'(wraddress));
      wr_data_q.push_back(int'(wrdata));
      if (!acc_prev) lat_err <= lat_err + 1;
    end
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_addr <= int'(wraddress);
      if (!wren) lat_err <= lat_err + 1;
    end
    acc_prev <= bus.in_valid && bus.in_ready && !rst;
  end

  // Reference model: byte stream and the RAM writes the header rules imply.
  logic [7:0] stim_q[$];
  int exp_addr[$];
  int exp_data[$];
  bit exp_ok;
  int exp_last;

  task automatic model_image(input int w, input int h, input int npix, input int pix_base);
    logic [7:0] b;
    int prod;
    stim_q.delete(); exp_addr.delete(); exp_data.delete();
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       b = w[15:8];
        1:       b = w[7:0];
        4:       b = h[15:8];
        5:       b = h[7:0];
        default: b = 8'($urandom);
      endcase
      stim_q.push_back(b);
      exp_addr.push_back(i);
      exp_data.push_back(int'(b));
    end
    prod     = w * h;
    exp_ok   = (w != 0) && (h != 0) && (prod <= 262128);
    exp_last = 15 + prod;
    for (int k = 0; k < npix; k++) begin
      b = (pix_base < 0) ? 8'($urandom) : 8'(pix_base + k);
      stim_q.push_back(b);
      if (exp_ok && k < prod) begin
        exp_addr.push_back(16 + k);
        exp_data.push_back(int'(b));
      end
    end
  endtask

  task automatic drive(input int gap_pct, input int start_at, output bit timed_out);
    int i = 0;
    int cycles = 0;
    bit acc, started;
    started = 1'b0;
    timed_out = 1'b0;
    while (i < stim_q.size() && !timed_out) begin
      if (!started && start_at >= 0 && i == start_at) begin
        start = 1'b1;
        started = 1'b1;
      end
      if (int'($urandom_range(99, 0)) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim_q[i];
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) i++;
      cycles++;
      if (cycles > 5000) timed_out = 1'b1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wren !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_flags: wren=%b done=%b error=%b, want 0", wren, done, error); end
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_busy_ready: busy=%b ready=%b, want 0", busy, bus.in_ready); end
    checks++; if (img_width !== 16'd0 || img_height !== 16'd0) begin errors++; $display("FAIL reset_dims: %0d x %0d, want 0 x 0", img_width, img_height); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int base, dbase, lbase;
    bit to;
    model_image(4, 2, 8, 'h10);
    base = wr_addr_q.size(); dbase = done_cnt; lbase = lat_err;
    bus.in_valid = 1'b1; bus.in_data = stim_q[0]; start = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_idle_ready: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    drive(0, -1, to);
    settle();
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: stream not consumed, want consumed"); end
    checks++; if (wr_addr_q.size() - base != exp_addr.size()) begin errors++; $display("FAIL basic_wr_count: got %0d want %0d", wr_addr_q.size() - base, exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && base + k < wr_addr_q.size(); k++) begin
      checks++; if (wr_addr_q[base+k] !== exp_addr[k] || wr_data_q[base+k] !== exp_data[k]) begin errors++; $display("FAIL basic_wr[%0d]: got %0h/%0h want %0h/%0h", k, wr_addr_q[base+k], wr_data_q[base+k], exp_addr[k], exp_data[k]); end
    end
    checks++; if (img_width !== 16'd4 || img_height !== 16'd2) begin errors++; $display("FAIL basic_dims: got %0d x %0d want 4 x 2", img_width, img_height); end
    checks++; if (done_cnt != dbase + 1 || done_addr != 'h17) begin errors++; $display("FAIL basic_done: got %0d pulses at %0h want 1 at 17", done_cnt - dbase, done_addr); end
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_after: ready=%b busy=%b want 0 0", bus.in_ready, busy); end
    checks++; if (lat_err != lbase) begin errors++; $display("FAIL basic_latency: got %0d bad writes want 0", lat_err - lbase); end
  endtask

  task automatic test_gaps_and_random();
    int base, dbase, lbase, w, h;
    bit to;
    for (int n = 0; n < 5; n++) begin
      w = (n == 0) ? 4 : int'($urandom_range(12, 1));
      h = (n == 0) ? 2 : int'($urandom_range(12, 1));
      model_image(w, h, w * h, -1);
      base = wr_addr_q.size(); dbase = done_cnt; lbase = lat_err;
      pulse_start();
      drive((n == 0) ? 50 : 30, -1, to);
      settle();
      checks++; if (to) begin errors++; $display("FAIL gaps_timeout[%0d]: stream not consumed", n); end
      checks++; if (wr_addr_q.size() - base != exp_addr.size()) begin errors++; $display("FAIL gaps_wr_count[%0d]: got %0d want %0d", n, wr_addr_q.size() - base, exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && base + k < wr_addr_q.size(); k++) begin
        checks++; if (wr_addr_q[base+k] !== exp_addr[k] || wr_data_q[base+k] !== exp_data[k]) begin errors++; $display("FAIL gaps_wr[%0d][%0d]: got %0h/%0h want %0h/%0h", n, k, wr_addr_q[base+k], wr_data_q[base+k], exp_addr[k], exp_data[k]); end
      end
      checks++; if (int'(img_width) != w || int'(img_height) != h) begin errors++; $display("FAIL gaps_dims[%0d]: got %0d x %0d want %0d x %0d", n, img_width, img_height, w, h); end
      checks++; if (done_cnt != dbase + 1 || done_addr != exp_last) begin errors++; $display("FAIL gaps_done[%0d]: got %0d pulses at %0h want 1 at %0h", n, done_cnt - dbase, done_addr, exp_last); end
      checks++; if (lat_err != lbase) begin errors++; $display("FAIL gaps_latency[%0d]: got %0d bad writes want 0", n, lat_err - lbase); end
    end
  endtask

  task automatic test_oversize();
    int base, dbase;
    bit to;
    model_image(512, 512, 50, -1);
    base = wr_addr_q.size(); dbase = done_cnt;
    pulse_start();
    drive(20, -1, to);
    settle();
    checks++; if (to) begin errors++; $display("FAIL oversize_drain: 50 bytes not accepted"); end
    checks++; if (wr_addr_q.size() - base != 16) begin errors++; $display("FAIL oversize_wr_count: got %0d want 16", wr_addr_q.size() - base); end
    checks++; if (error !== 1'b1 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL oversize_state: error=%b ready=%b busy=%b want 1 1 0", error, bus.in_ready, busy); end
    checks++; if (done_cnt != dbase) begin errors++; $display("FAIL oversize_done: got %0d pulses want 0", done_cnt - dbase); end
  endtask

  task automatic test_zero_dim();
    int base, dbase;
    bit to;
    model_image(0, 5, 0, -1);
    base = wr_addr_q.size();
    pulse_start();
    drive(0, -1, to);
    settle();
    checks++; if (error !== 1'b1 || wr_addr_q.size() - base != 16) begin errors++; $display("FAIL zero_error: error=%b writes=%0d want 1 16", error, wr_addr_q.size() - base); end
    pulse_start();
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_rearm: error=%b busy=%b want 0 1", error, busy); end
    model_image(1, 1, 1, -1);
    base = wr_addr_q.size(); dbase = done_cnt;
    drive(0, -1, to);
    settle();
    checks++; if (wr_addr_q.size() - base != 17 || (wr_addr_q.size() > base + 16 && wr_data_q[base+16] != exp_data[16])) begin errors++; $display("FAIL zero_1x1_writes: got %0d want 17", wr_addr_q.size() - base); end
    checks++; if (done_cnt != dbase + 1 || done_addr != 'h10) begin errors++; $display("FAIL zero_1x1_done: got %0d pulses at %0h want 1 at 10", done_cnt - dbase, done_addr); end
  endtask

  task automatic test_reset_mid();
    int base, dbase;
    bit to;
    logic [7:0] pix3;
    model_image(4, 2, 8, 'h20);
    pix3 = stim_q[19];
    repeat (5) stim_q.pop_back();
    base = wr_addr_q.size(); dbase = done_cnt;
    pulse_start();
    drive(0, -1, to);
    bus.in_valid = 1'b1; bus.in_data = pix3; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    checks++; if (wren !== 1'b0 || busy !== 1'b0 || img_width !== 16'd0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state: wren=%b busy=%b width=%0d ready=%b want 0 0 0 0", wren, busy, img_width, bus.in_ready); end
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    settle();
    checks++; if (wr_addr_q.size() - base != 19 || done_cnt != dbase) begin errors++; $display("FAIL rstmid_writes: got %0d writes %0d done want 19 0", wr_addr_q.size() - base, done_cnt - dbase); end
    for (int k = 0; k < 19 && base + k < wr_addr_q.size(); k++) begin
      checks++; if (wr_addr_q[base+k] !== exp_addr[k] || wr_data_q[base+k] !== exp_data[k]) begin errors++; $display("FAIL rstmid_wr[%0d]: got %0h/%0h want %0h/%0h", k, wr_addr_q[base+k], wr_data_q[base+k], exp_addr[k], exp_data[k]); end
    end
  endtask

  task automatic test_start_busy();
    int base, dbase;
    bit to;
    model_image(3, 3, 9, -1);
    base = wr_addr_q.size(); dbase = done_cnt;
    pulse_start();
    drive(25, 20, to);
    settle();
    checks++; if (to || wr_addr_q.size() - base != exp_addr.size()) begin errors++; $display("FAIL startbusy_wr_count: got %0d want %0d", wr_addr_q.size() - base, exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && base + k < wr_addr_q.size(); k++) begin
      checks++; if (wr_addr_q[base+k] !== exp_addr[k] || wr_data_q[base+k] !== exp_data[k]) begin errors++; $display("FAIL startbusy_wr[%0d]: got %0h/%0h want %0h/%0h", k, wr_addr_q[base+k], wr_data_q[base+k], exp_addr[k], exp_data[k]); end
    end
    checks++; if (done_cnt != dbase + 1 || done_addr != exp_last) begin errors++; $display("FAIL startbusy_done: got %0d pulses at %0h want 1 at %0h", done_cnt - dbase, done_addr, exp_last); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0;
    test_reset();
    test_basic();
    test_gaps_and_random();
    test_oversize();
    test_zero_dim();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
